// File: rtl/offset_cal_ctrl.sv
// rtl/offset_cal_ctrl.sv - foreground ADC offset calibration controller
// Shorts the input, settles, averages 2^LOG2_N codes and registers a clamped mid-scale correction.
module offset_cal_ctrl #(
  parameter int LOG2_N        = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int MID_CODE      = 512,
  parameter int MAX_OFFSET    = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cal_start,
  input  logic       cal_abort,
  input  logic       adc_valid,
  input  logic [9:0] adc_code,
  output logic       cal_short,
  output logic [9:0] offset,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_err
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = 10 + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ACCUM,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [SET_W-1:0]   settle_cnt, settle_next;
  logic [9:0]         offset_next;
  logic               err_next;

  logic [ACC_W:0]     acc_rnd;
  logic [10:0]        avg;
  logic signed [11:0] diff;

  // Round half up before dropping the fractional bits of the average.
  assign acc_rnd = {1'b0, acc} + (ACC_W + 1)'(N / 2);
  assign avg     = 11'(acc_rnd >> LOG2_N);
  assign diff    = $signed(12'(MID_CODE)) - $signed({1'b0, avg});

  always_comb begin
    state_next  = state;
    acc_next    = acc;
    cnt_next    = cnt;
    settle_next = settle_cnt;
    offset_next = offset;
    err_next    = cal_err;
    case (state)
      S_IDLE: begin
        if (cal_start) begin
          state_next  = S_SETTLE;
          acc_next    = '0;
          cnt_next    = '0;
          settle_next = '0;
          err_next    = 1'b0;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          state_next  = S_ACCUM;
          settle_next = '0;
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end
      S_ACCUM: begin
        if (adc_valid) begin
          acc_next = acc + ACC_W'(adc_code);
          cnt_next = cnt + 1'b1;
          if (cnt == CNT_W'(N - 1)) state_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        state_next = S_DONE;
        if (diff > $signed(12'(MAX_OFFSET))) begin
          offset_next = 10'(MAX_OFFSET);
          err_next    = 1'b1;
        end else if (diff < -$signed(12'(MAX_OFFSET))) begin
          offset_next = 10'(-MAX_OFFSET);
          err_next    = 1'b1;
        end else begin
          offset_next = 10'(diff);
          err_next    = 1'b0;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Abort wins over every other transition and leaves the applied result untouched.
    if (cal_abort && (state == S_SETTLE || state == S_ACCUM || state == S_COMPUTE)) begin
      state_next  = S_IDLE;
      offset_next = offset;
      err_next    = cal_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      acc        <= '0;
      cnt        <= '0;
      settle_cnt <= '0;
      offset     <= '0;
      cal_err    <= 1'b0;
      cal_short  <= 1'b0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      cnt        <= cnt_next;
      settle_cnt <= settle_next;
      offset     <= offset_next;
      cal_err    <= err_next;
      cal_short  <= (state_next == S_SETTLE) || (state_next == S_ACCUM);
      cal_busy   <= (state_next != S_IDLE);
      cal_done   <= (state_next == S_DONE);
    end
  end

endmodule
